cpu_dcache_line: RTL and testbench

Parametrised direct-mapped write-back data cache with multi-word lines, byte-masked writes, write-allocate, flush/invalidate modes and hit/miss counters. Sits between the CPU load/store unit and the single-word system bus; uncacheable accesses pass straight through. It replaces the one-word-per-entry data cache, keeping its request/ready handshake and adding line refill and eviction bursts.

---
 rtl/cpu_dcache_line.sv | 254 +++++++++++++++++++++++++
 tb/tb_cpu_dcache_line.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_dcache_line.sv
// Direct-mapped write-back data cache with multi-word lines, byte-masked writes,
// write-allocate, flush/invalidate and uncacheable pass-through on a single-word bus.
module cpu_dcache_line #(
   parameter int INDEX_BITS = 8,
   parameter int LINE_WORDS = 4
) (
   input  logic        i_clock,
   input  logic        i_reset,
   output logic        o_bus_request,
   output logic        o_bus_rw,
   input  logic        i_bus_ready,
   output logic [31:0] o_bus_address,
   output logic [31:0] o_bus_wdata,
   output logic [3:0]  o_bus_wmask,
   input  logic [31:0] i_bus_rdata,
   input  logic        i_request,
   input  logic        i_rw,
   input  logic        i_flush,
   input  logic        i_flush_inv,
   input  logic        i_cacheable,
   input  logic [31:0] i_address,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_wmask,
   output logic        o_ready,
   output logic [31:0] o_rdata,
   output logic [31:0] o_hit,
   output logic [31:0] o_miss
);
   localparam int OFF   = $clog2(LINE_WORDS);
   localparam int WB    = (OFF > 0) ? OFF : 1;
   localparam int TAG_W = 30 - INDEX_BITS - OFF;
   localparam int LINES = 1 << INDEX_BITS;
   localparam int DA    = INDEX_BITS + WB;
   localparam logic [WB-1:0]         LAST_WORD  = WB'(LINE_WORDS - 1);
   localparam logic [INDEX_BITS-1:0] LAST_INDEX = INDEX_BITS'(LINES - 1);

   typedef enum logic [3:0] {
      S_INIT, S_IDLE, S_LOOKUP, S_EVICT, S_FILL, S_PASS,
      S_FLUSH_RD, S_FLUSH_CHK, S_FLUSH_EVICT
   } state_t;

   typedef struct packed {
      logic             valid;
      logic             dirty;
      logic [TAG_W-1:0] tag;
   } meta_t;

   meta_t       r_meta_mem [LINES];
   logic [31:0] r_data_mem [1 << DA];
   meta_t       r_meta_q;
   logic [31:0] r_data_q;

   state_t                  r_state, w_state_next;
   logic [INDEX_BITS-1:0]   r_init_idx, r_fidx;
   logic [WB-1:0]           r_word;
   logic                    r_phase, r_primed, r_refilled;
   logic                    r_bus_req, r_bus_rw, r_ready;
   logic [31:0]             r_bus_addr, r_bus_wdata, r_rdata, r_hit, r_miss;
   logic [3:0]              r_bus_wmask;

   logic [WB-1:0]           w_word, w_word_inc;
   logic [INDEX_BITS-1:0]   w_index, w_evict_idx, w_meta_raddr, w_meta_waddr;
   logic [TAG_W-1:0]        w_tag;
   logic                    w_ack, w_accept, w_hit, w_victim_dirty, w_last_word, w_evicting;
   logic [31:0]             w_merged, w_evict_addr, w_fill_addr;
   logic                    w_meta_we, w_data_we;
   meta_t                   w_meta_wdata;
   logic [DA-1:0]           w_data_raddr, w_data_waddr;
   logic [31:0]             w_data_wdata;

   assign w_word         = i_address[2 +: WB] & LAST_WORD;
   assign w_index        = i_address[OFF + 2 +: INDEX_BITS];
   assign w_tag          = i_address[31 -: TAG_W];
   assign w_word_inc     = r_word + WB'(1);
   assign w_last_word    = (r_word == LAST_WORD);
   assign w_ack          = r_bus_req && i_bus_ready;
   assign w_accept       = (r_state == S_IDLE) && i_request && !r_ready;
   assign w_hit          = r_meta_q.valid && (r_meta_q.tag == w_tag);
   assign w_victim_dirty = r_meta_q.valid && r_meta_q.dirty;
   assign w_evicting     = (r_state == S_EVICT) || (r_state == S_FLUSH_EVICT);
   assign w_evict_idx    = (r_state == S_FLUSH_EVICT) ? r_fidx : w_index;
   assign w_evict_addr   = (32'({r_meta_q.tag, w_evict_idx}) << (OFF + 2)) | (32'(r_word) << 2);
   assign w_fill_addr    = (32'({w_tag, w_index}) << (OFF + 2)) | (32'(r_word) << 2);

   for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign w_merged[8*gi +: 8] = i_wmask[gi] ? i_wdata[8*gi +: 8] : r_data_q[8*gi +: 8];
   end

   // Flush walks r_fidx; everything else looks at the requested line.
   assign w_meta_raddr = (r_state == S_FLUSH_RD || r_state == S_FLUSH_CHK ||
                          r_state == S_FLUSH_EVICT) ? r_fidx : w_index;
   // During eviction read one word ahead so the next write data is ready when the bus frees.
   assign w_data_raddr = w_evicting ? {w_evict_idx, (w_ack ? w_word_inc : r_word)}
                                    : {w_index, w_word};

   always_ff @(posedge i_clock) begin
      if (w_meta_we) r_meta_mem[w_meta_waddr] <= w_meta_wdata;
      if (w_data_we) r_data_mem[w_data_waddr] <= w_data_wdata;
      r_meta_q <= r_meta_mem[w_meta_raddr];
      r_data_q <= r_data_mem[w_data_raddr];
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) r_state <= S_INIT;
      else         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_INIT:        if (r_init_idx == LAST_INDEX) w_state_next = S_IDLE;
         S_IDLE:        if (w_accept) w_state_next = i_flush ? S_FLUSH_RD :
                                                     (i_cacheable ? S_LOOKUP : S_PASS);
         S_LOOKUP:      if (r_phase) w_state_next = w_hit ? S_IDLE :
                                                    (w_victim_dirty ? S_EVICT : S_FILL);
         S_EVICT:       if (w_ack && w_last_word) w_state_next = S_FILL;
         S_FILL:        if (w_ack && w_last_word) w_state_next = S_LOOKUP;
         S_PASS:        if (w_ack) w_state_next = S_IDLE;
         S_FLUSH_RD:    w_state_next = S_FLUSH_CHK;
         S_FLUSH_CHK:   w_state_next = w_victim_dirty ? S_FLUSH_EVICT :
                                       ((r_fidx == LAST_INDEX) ? S_IDLE : S_FLUSH_RD);
         S_FLUSH_EVICT: if (w_ack && w_last_word) w_state_next = S_FLUSH_RD;
         default:       w_state_next = S_INIT;
      endcase
   end

   always_comb begin
      w_meta_we    = 1'b0;
      w_meta_waddr = w_index;
      w_meta_wdata = '0;
      w_data_we    = 1'b0;
      w_data_waddr = {w_index, w_word};
      w_data_wdata = w_merged;
      case (r_state)
         S_INIT: begin
            w_meta_we    = 1'b1;
            w_meta_waddr = r_init_idx;
         end
         S_LOOKUP: if (r_phase && w_hit && i_rw) begin
            w_data_we    = 1'b1;
            w_meta_we    = 1'b1;
            w_meta_wdata = '{valid: 1'b1, dirty: 1'b1, tag: w_tag};
         end
         S_FILL: if (w_ack) begin
            w_data_we    = 1'b1;
            w_data_waddr = {w_index, r_word};
            w_data_wdata = i_bus_rdata;
            w_meta_we    = w_last_word;
            w_meta_wdata = '{valid: 1'b1, dirty: 1'b0, tag: w_tag};
         end
         S_FLUSH_CHK: if (!w_victim_dirty && i_flush_inv) begin
            w_meta_we    = 1'b1;
            w_meta_waddr = r_fidx;
         end
         // Cleaned line is re-read and re-checked, which also applies the invalidate.
         S_FLUSH_EVICT: if (w_ack && w_last_word) begin
            w_meta_we    = 1'b1;
            w_meta_waddr = r_fidx;
            w_meta_wdata = '{valid: r_meta_q.valid, dirty: 1'b0, tag: r_meta_q.tag};
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_init_idx <= '0;  r_fidx <= '0;  r_word <= '0;
         r_phase <= 1'b0;   r_primed <= 1'b0;  r_refilled <= 1'b0;
         r_bus_req <= 1'b0; r_bus_rw <= 1'b0;  r_bus_addr <= '0;
         r_bus_wdata <= '0; r_bus_wmask <= '0; r_ready <= 1'b0;
         r_rdata <= '0;     r_hit <= '0;       r_miss <= '0;
      end else begin
         r_ready <= 1'b0;
         if (w_ack) r_bus_req <= 1'b0;
         case (r_state)
            S_INIT: r_init_idx <= r_init_idx + INDEX_BITS'(1);
            S_IDLE: if (w_accept) begin
               r_phase    <= 1'b0;
               r_refilled <= 1'b0;
               r_fidx     <= '0;
            end
            S_LOOKUP: begin
               r_phase <= !r_phase;
               if (r_phase && w_hit) begin
                  r_ready <= 1'b1;
                  if (!i_rw)       r_rdata <= r_data_q;
                  if (!r_refilled) r_hit   <= r_hit + 32'd1;
               end else if (r_phase) begin
                  r_miss   <= r_miss + 32'd1;
                  r_word   <= '0;
                  r_primed <= 1'b0;
               end
            end
            S_EVICT, S_FLUSH_EVICT: begin
               if (!r_bus_req && !r_primed) begin
                  r_primed <= 1'b1;
               end else if (!r_bus_req) begin
                  r_bus_req   <= 1'b1;
                  r_bus_rw    <= 1'b1;
                  r_bus_addr  <= w_evict_addr;
                  r_bus_wdata <= r_data_q;
                  r_bus_wmask <= 4'hF;
               end else if (w_ack) begin
                  r_word <= w_last_word ? '0 : w_word_inc;
               end
            end
            S_FILL: begin
               if (!r_bus_req) begin
                  r_bus_req   <= 1'b1;
                  r_bus_rw    <= 1'b0;
                  r_bus_addr  <= w_fill_addr;
                  r_bus_wmask <= 4'hF;
               end else if (w_ack) begin
                  r_word <= w_last_word ? '0 : w_word_inc;
               end
               if (w_ack && w_last_word) r_refilled <= 1'b1;
            end
            S_PASS: begin
               if (!r_bus_req) begin
                  r_bus_req   <= 1'b1;
                  r_bus_rw    <= i_rw;
                  r_bus_addr  <= i_address & 32'hFFFF_FFFC;
                  r_bus_wdata <= i_wdata;
                  r_bus_wmask <= i_rw ? i_wmask : 4'hF;
               end else if (w_ack) begin
                  r_rdata <= i_bus_rdata;
                  r_ready <= 1'b1;
               end
            end
            S_FLUSH_CHK: begin
               if (w_victim_dirty) begin
                  r_word   <= '0;
                  r_primed <= 1'b0;
               end else if (r_fidx == LAST_INDEX) begin
                  r_ready <= 1'b1;
               end else begin
                  r_fidx <= r_fidx + INDEX_BITS'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign o_bus_request = r_bus_req;
   assign o_bus_rw      = r_bus_rw;
   assign o_bus_address = r_bus_addr;
   assign o_bus_wdata   = r_bus_wdata;
   assign o_bus_wmask   = r_bus_wmask;
   assign o_ready       = r_ready;
   assign o_rdata       = r_rdata;
   assign o_hit         = r_hit;
   assign o_miss        = r_miss;
endmodule

// File: tb/tb_cpu_dcache_line.sv
// Directed bench for cpu_dcache_line: 16 lines of 4 words, zero-wait bus model with memory.
module tb_cpu_dcache_line;
   logic        i_clock, i_reset;
   logic        o_bus_request, o_bus_rw, i_bus_ready;
   logic [31:0] o_bus_address, o_bus_wdata, i_bus_rdata;
   logic [3:0]  o_bus_wmask;
   logic        i_request, i_rw, i_flush, i_flush_inv, i_cacheable;
   logic [31:0] i_address, i_wdata;
   logic [3:0]  i_wmask;
   logic        o_ready;
   logic [31:0] o_rdata, o_hit, o_miss;

   int vectors = 0;
   int miscompares = 0;
   int ready_cnt = 0;

   typedef struct {
      logic        rw;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } bus_t;
   bus_t        blog[$];
   logic [31:0] mem [logic [31:0]];

   cpu_dcache_line #(.INDEX_BITS(4), .LINE_WORDS(4)) dut (
      .i_clock(i_clock), .i_reset(i_reset),
      .o_bus_request(o_bus_request), .o_bus_rw(o_bus_rw), .i_bus_ready(i_bus_ready),
      .o_bus_address(o_bus_address), .o_bus_wdata(o_bus_wdata), .o_bus_wmask(o_bus_wmask),
      .i_bus_rdata(i_bus_rdata), .i_request(i_request), .i_rw(i_rw),
      .i_flush(i_flush), .i_flush_inv(i_flush_inv), .i_cacheable(i_cacheable),
      .i_address(i_address), .i_wdata(i_wdata), .i_wmask(i_wmask),
      .o_ready(o_ready), .o_rdata(o_rdata), .o_hit(o_hit), .o_miss(o_miss)
   );

   initial begin
      i_clock = 1'b0;
      forever #5 i_clock = ~i_clock;
   end

   function automatic logic [31:0] pat(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return pat(a);
   endfunction

   // Bus slave: acknowledges each request one half-cycle after it appears.
   initial begin
      bus_t        t;
      logic [31:0] w;
      i_bus_ready = 1'b0;
      i_bus_rdata = '0;
      forever begin
         @(negedge i_clock);
         if (o_bus_request && !i_bus_ready && !i_reset) begin
            t.rw = o_bus_rw; t.addr = o_bus_address; t.wdata = o_bus_wdata; t.wmask = o_bus_wmask;
            blog.push_back(t);
            if (o_bus_rw) begin
               w = mem_rd(o_bus_address);
               for (int b = 0; b < 4; b++)
                  if (o_bus_wmask[b]) w[8*b +: 8] = o_bus_wdata[8*b +: 8];
               mem[o_bus_address] = w;
            end else begin
               i_bus_rdata = mem_rd(o_bus_address);
            end
            i_bus_ready = 1'b1;
         end else begin
            i_bus_ready = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge i_clock);
         #1;
         if (o_ready) ready_cnt++;
      end
   end

   task automatic do_access(input logic fl, input logic inv, input logic cach, input logic rw,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wm, output logic [31:0] rdata, output int cycles);
      @(negedge i_clock);
      i_flush = fl; i_flush_inv = inv; i_cacheable = cach; i_rw = rw;
      i_address = addr; i_wdata = wdata; i_wmask = wm; i_request = 1'b1;
      cycles = 0;
      rdata = '0;
      while (cycles < 3000) begin
         @(posedge i_clock);
         #1;
         cycles++;
         if (o_ready) break;
      end
      if (!o_ready) begin
         vectors++; miscompares++;
         $display("FAIL access_timeout: addr %h got no o_ready after %0d cycles, required o_ready", addr, cycles);
      end else begin
         rdata = o_rdata;
      end
      @(negedge i_clock);
      i_request = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %b required 0", o_ready); end
      vectors++; if (o_bus_request !== 1'b0) begin miscompares++; $display("FAIL rst_bus_req: got %b required 0", o_bus_request); end
      vectors++; if ({o_bus_rw, o_bus_address, o_bus_wdata, o_bus_wmask} !== '0) begin miscompares++; $display("FAIL rst_bus_out: got %h/%h/%h required 0", o_bus_address, o_bus_wdata, o_bus_wmask); end
      vectors++; if ({o_rdata, o_hit, o_miss} !== '0) begin miscompares++; $display("FAIL rst_cpu_out: got %h/%0d/%0d required 0", o_rdata, o_hit, o_miss); end
      repeat (3) @(negedge i_clock);
      i_reset = 1'b0;
   endtask

   task automatic test_miss_fill();
      logic [31:0] rd; int cyc;
      blog.delete();
      do_access(1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, rd, cyc);
      $display("miss read 0x100: rdata %h, %0d bus ops, %0d cycles", rd, blog.size(), cyc);
      vectors++; if (rd !== pat(32'h100)) begin miscompares++; $display("FAIL miss_rdata: got %h required %h", rd, pat(32'h100)); end
      vectors++; if (blog.size() !== 4) begin miscompares++; $display("FAIL miss_bus_count: got %0d required 4", blog.size()); end
      for (int k = 0; k < 4; k++) if (k < blog.size()) begin
         vectors++;
         if (blog[k].rw !== 1'b0 || blog[k].addr !== 32'h100 + 32'(4*k)) begin
            miscompares++; $display("FAIL miss_fill_op%0d: got rw %b addr %h required rw 0 addr %h", k, blog[k].rw, blog[k].addr, 32'h100 + 32'(4*k));
         end
      end
      vectors++; if (o_miss !== 32'd1 || o_hit !== 32'd0) begin miscompares++; $display("FAIL miss_counters: got hit %0d miss %0d required 0/1", o_hit, o_miss); end
   endtask

   task automatic test_hit();
      logic [31:0] rd; int cyc;
      blog.delete();
      do_access(1'b0, 1'b0, 1'b1, 1'b0, 32'h108, 32'h0, 4'h0, rd, cyc);
      $display("hit read 0x108: rdata %h, %0d bus ops, %0d cycles", rd, blog.size(), cyc);
      vectors++; if (cyc !== 3) begin miscompares++; $display("FAIL hit_latency: got %0d cycles required 3", cyc); end
      vectors++; if (rd !== pat(32'h108)) begin miscompares++; $display("FAIL hit_rdata: got %h required %h", rd, pat(32'h108)); end
      vectors++; if (blog.size() !== 0) begin miscompares++; $display("FAIL hit_bus_count: got %0d required 0", blog.size()); end
      vectors++; if (o_hit !== 32'd1 || o_miss !== 32'd1) begin miscompares++; $display("FAIL hit_counters: got hit %0d miss %0d required 1/1", o_hit, o_miss); end
   endtask

   task automatic test_write_merge();
      logic [31:0] rd; int cyc;
      blog.delete();
      do_access(1'b0, 1'b0, 1'b1, 1'b1, 32'h104, 32'hAABBCCDD, 4'b0011, rd, cyc);
      do_access(1'b0, 1'b0, 1'b1, 1'b0, 32'h104, 32'h0, 4'h0, rd, cyc);
      $display("write-merge 0x104 then read: rdata %h, %0d bus ops", rd, blog.size());
      vectors++; if (rd !== 32'h1122CCDD) begin miscompares++; $display("FAIL merge_rdata: got %h required 1122ccdd", rd); end
      vectors++; if (blog.size() !== 0) begin miscompares++; $display("FAIL merge_bus_count: got %0d required 0", blog.size()); end
      vectors++; if (o_hit !== 32'd3) begin miscompares++; $display("FAIL merge_hits: got %0d required 3", o_hit); end
   endtask

   task automatic test_conflict();
      logic [31:0] rd; int cyc;
      logic [31:0] exp_wb [4];
      exp_wb[0] = pat(32'h100); exp_wb[1] = 32'h1122CCDD; exp_wb[2] = pat(32'h108); exp_wb[3] = pat(32'h10C);
      blog.delete();
      do_access(1'b0, 1'b0, 1'b1, 1'b0, 32'h504, 32'h0, 4'h0, rd, cyc);
      $display("conflict read 0x504: rdata %h, %0d bus ops", rd, blog.size());
      vectors++; if (blog.size() !== 8) begin miscompares++; $display("FAIL conf_bus_count: got %0d required 8", blog.size()); end
      for (int k = 0; k < 8; k++) if (k < blog.size()) begin
         vectors++;
         if (k < 4 && (blog[k].rw !== 1'b1 || blog[k].addr !== 32'h100 + 32'(4*k) ||
                       blog[k].wdata !== exp_wb[k] || blog[k].wmask !== 4'hF)) begin
            miscompares++; $display("FAIL conf_evict%0d: got rw %b addr %h data %h mask %h required 1 %h %h f", k, blog[k].rw, blog[k].addr, blog[k].wdata, blog[k].wmask, 32'h100 + 32'(4*k), exp_wb[k]);
         end
         if (k >= 4 && (blog[k].rw !== 1'b0 || blog[k].addr !== 32'h500 + 32'(4*(k-4)))) begin
            miscompares++; $display("FAIL conf_fill%0d: got rw %b addr %h required 0 %h", k, blog[k].rw, blog[k].addr, 32'h500 + 32'(4*(k-4)));
         end
      end
      vectors++; if (rd !== pat(32'h504)) begin miscompares++; $display("FAIL conf_rdata: got %h required %h", rd, pat(32'h504)); end
      vectors++; if (o_miss !== 32'd2) begin miscompares++; $display("FAIL conf_misses: got %0d required 2", o_miss); end
   endtask

   task automatic test_flush();
      logic [31:0] rd; int cyc; int r0;
      logic [31:0] exp_a [8];
      logic [31:0] exp_d [8];
      do_access(1'b0, 1'b0, 1'b1, 1'b1, 32'h500, 32'hDEADBEEF, 4'hF, rd, cyc);
      do_access(1'b0, 1'b0, 1'b1, 1'b1, 32'h210, 32'h0BADF00D, 4'b0101, rd, cyc);
      for (int k = 0; k < 4; k++) begin
         exp_a[k] = 32'h500 + 32'(4*k); exp_d[k] = pat(exp_a[k]);
         exp_a[k+4] = 32'h210 + 32'(4*k); exp_d[k+4] = pat(exp_a[k+4]);
      end
      exp_d[0] = 32'hDEADBEEF;
      exp_d[4] = (pat(32'h210) & 32'hFF00FF00) | (32'h0BADF00D & 32'h00FF00FF);
      blog.delete();
      r0 = ready_cnt;
      do_access(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, rd, cyc);
      $display("flush+inv: %0d bus ops, %0d ready pulses, %0d cycles", blog.size(), ready_cnt - r0, cyc);
      vectors++; if (blog.size() !== 8) begin miscompares++; $display("FAIL flush_bus_count: got %0d required 8", blog.size()); end
      for (int k = 0; k < 8; k++) if (k < blog.size()) begin
         vectors++;
         if (blog[k].rw !== 1'b1 || blog[k].addr !== exp_a[k] || blog[k].wdata !== exp_d[k]) begin
            miscompares++; $display("FAIL flush_wr%0d: got rw %b addr %h data %h required 1 %h %h", k, blog[k].rw, blog[k].addr, blog[k].wdata, exp_a[k], exp_d[k]);
         end
      end
      vectors++; if (ready_cnt - r0 !== 1) begin miscompares++; $display("FAIL flush_ready_pulses: got %0d required 1", ready_cnt - r0); end
      vectors++; if (o_hit !== 32'd4 || o_miss !== 32'd3) begin miscompares++; $display("FAIL flush_counters: got hit %0d miss %0d required 4/3", o_hit, o_miss); end
      vectors++; if (cyc < 32) begin miscompares++; $display("FAIL flush_duration: got %0d cycles required >= 32", cyc); end
      blog.delete();
      do_access(1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, rd, cyc);
      $display("read 0x100 after flush: rdata %h, %0d bus ops, miss %0d", rd, blog.size(), o_miss);
      vectors++; if (o_miss !== 32'd4) begin miscompares++; $display("FAIL postflush_miss: got %0d required 4", o_miss); end
      vectors++; if (blog.size() !== 4 || (blog.size() > 0 && blog[0].rw !== 1'b0)) begin miscompares++; $display("FAIL postflush_bus: got %0d ops required 4 reads", blog.size()); end
      vectors++; if (rd !== pat(32'h100)) begin miscompares++; $display("FAIL postflush_rdata: got %h required %h", rd, pat(32'h100)); end
   endtask

   task automatic test_pass();
      logic [31:0] rd; int cyc;
      blog.delete();
      do_access(1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'hCAFEF00D, 4'b1000, rd, cyc);
      do_access(1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, rd, cyc);
      $display("pass-through write+read: rdata %h, %0d bus ops", rd, blog.size());
      vectors++; if (blog.size() !== 2) begin miscompares++; $display("FAIL pass_bus_count: got %0d required 2", blog.size()); end
      if (blog.size() > 1) begin
         vectors++;
         if (blog[0].rw !== 1'b1 || blog[0].addr !== 32'h8000_0000 || blog[0].wmask !== 4'b1000 || blog[0].wdata !== 32'hCAFEF00D) begin
            miscompares++; $display("FAIL pass_write: got %b %h %h %h required 1 80000000 cafef00d 8", blog[0].rw, blog[0].addr, blog[0].wdata, blog[0].wmask);
         end
         vectors++;
         if (blog[1].rw !== 1'b0 || blog[1].addr !== 32'h8000_0010 || blog[1].wmask !== 4'hF) begin
            miscompares++; $display("FAIL pass_read: got %b %h %h required 0 80000010 f", blog[1].rw, blog[1].addr, blog[1].wmask);
         end
      end
      vectors++; if (rd !== pat(32'h8000_0010)) begin miscompares++; $display("FAIL pass_rdata: got %h required %h", rd, pat(32'h8000_0010)); end
      vectors++; if (o_hit !== 32'd4 || o_miss !== 32'd4) begin miscompares++; $display("FAIL pass_counters: got hit %0d miss %0d required 4/4", o_hit, o_miss); end
   endtask

   task automatic test_reset_mid_fill();
      logic [31:0] rd; int cyc; int n;
      @(negedge i_clock);
      i_flush = 1'b0; i_cacheable = 1'b1; i_rw = 1'b0; i_address = 32'h300; i_request = 1'b1;
      n = 0;
      while (n < 200) begin
         @(posedge i_clock);
         #2;
         n++;
         if (o_bus_request) break;
      end
      vectors++; if (o_bus_request !== 1'b1) begin miscompares++; $display("FAIL rstfill_no_req: got %b required 1", o_bus_request); end
      i_reset = 1'b1;
      #1;
      vectors++; if (o_bus_request !== 1'b0) begin miscompares++; $display("FAIL rstfill_req_drop: got %b required 0", o_bus_request); end
      i_request = 1'b0;
      repeat (2) @(negedge i_clock);
      i_reset = 1'b0;
      blog.delete();
      do_access(1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0, rd, cyc);
      $display("read 0x300 after mid-fill reset: rdata %h, %0d bus ops, miss %0d hit %0d", rd, blog.size(), o_miss, o_hit);
      vectors++; if (o_miss !== 32'd1 || o_hit !== 32'd0) begin miscompares++; $display("FAIL rstfill_counters: got hit %0d miss %0d required 0/1", o_hit, o_miss); end
      vectors++; if (blog.size() !== 4) begin miscompares++; $display("FAIL rstfill_bus_count: got %0d required 4", blog.size()); end
      vectors++; if (rd !== pat(32'h300)) begin miscompares++; $display("FAIL rstfill_rdata: got %h required %h", rd, pat(32'h300)); end
   endtask

   initial begin
      i_reset = 1'b1; i_request = 1'b0; i_rw = 1'b0; i_flush = 1'b0; i_flush_inv = 1'b0;
      i_cacheable = 1'b0; i_address = '0; i_wdata = '0; i_wmask = '0;
      mem[32'h104] = 32'h11223344;
      test_reset();
      test_miss_fill();
      test_hit();
      test_write_merge();
      test_conflict();
      test_flush();
      test_pass();
      test_reset_mid_fill();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
